// File: rtl/async_fifo_wr_arbiter.sv
// rtl/async_fifo_wr_arbiter.sv - round-robin burst arbiter for the async FIFO write port
//
// Purpose:
//   Shares the single write port of the asynchronous FIFO among N_REQ
//   requesters in the w_clk domain. Whole bursts are granted. A burst ends on a
//   beat marked req_last, or when the beat cap MAX_BURST is reached. FIFO full
//   back-pressures the granted requester, so the FIFO never sees a write while
//   it is full.
//
// Ports:
//   w_clk       in   write-domain clock
//   rst         in   synchronous, active-high reset
//   req         in   [N_REQ]        per-requester request, held until last beat accepted
//   req_data    in   [N_REQ*WIDTH]  packed data, requester i at [i*WIDTH +: WIDTH]
//   req_last    in   [N_REQ]        final beat of the requester's burst
//   req_ready   out  [N_REQ]        beat-accept strobe (combinational)
//   grant       out  [N_REQ]        registered one-hot owner, 0 when idle
//   fifo_wr_en  out                 FIFO write enable (combinational)
//   fifo_wdata  out  [WIDTH]        granted requester's data, 0 when idle
//   fifo_full   in                  FIFO full flag, w_clk domain
//   busy        out                 registered, high while a burst is granted
//   beat_cnt    out  [CNT_W]        registered, beats accepted in current burst

module async_fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                     w_clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         grant,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wdata,
  input  logic                     fifo_full,
  output logic                     busy,
  output logic [CNT_W-1:0]         beat_cnt
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t            state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]  last_owner_q;
  logic              busy_q;
  logic [CNT_W-1:0]  beat_cnt_q;

  logic [IDX_W-1:0]  owner_idx;
  logic [IDX_W-1:0]  arb_base;
  logic [N_REQ-1:0]  arb_mask;
  logic              arb_found;
  logic [IDX_W-1:0]  arb_idx;
  logic [N_REQ-1:0]  arb_onehot;
  logic              beat;
  logic              burst_end;
  logic [WIDTH-1:0]  wdata_mux;

  // Index of the current owner; only meaningful while grant_q is non-zero.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx = IDX_W'(i);
      end
    end
  end

  // Round-robin search starting just after the base index. In BURST the search
  // is only consumed at burst end, so the base is the current owner and its own
  // request is masked: a requester cut off by the beat cap, or one that starts
  // a new burst straight away, queues behind everyone else who is pending.
  always_comb begin
    int cand;
    arb_base   = (state_q == ST_BURST) ? owner_idx : last_owner_q;
    arb_mask   = (state_q == ST_BURST) ? (req & ~grant_q) : req;
    arb_found  = 1'b0;
    arb_idx    = '0;
    cand       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(arb_base) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!arb_found && arb_mask[IDX_W'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
    arb_onehot = arb_found ? (N_REQ'(1) << arb_idx) : '0;
  end

  // Only the owner may be offered a slot, and never while the FIFO is full.
  assign req_ready = rst ? '0 : (grant_q & {N_REQ{~fifo_full}});
  assign beat      = |(req & req_ready);
  assign burst_end = beat &
                     ((|(req_last & grant_q)) || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));

  // grant_q is one-hot or zero, so an OR-mux is enough and idles at zero.
  always_comb begin
    wdata_mux = '0;
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_q[i]) begin
          wdata_mux = req_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign fifo_wr_en = beat;
  assign fifo_wdata = wdata_mux;

  always_ff @(posedge w_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      beat_cnt_q   <= '0;
      last_owner_q <= IDX_W'(N_REQ - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            grant_q    <= arb_onehot;
            state_q    <= ST_BURST;
            busy_q     <= 1'b1;
            beat_cnt_q <= '0;
          end
        end
        ST_BURST: begin
          if (beat) begin
            if (burst_end) begin
              last_owner_q <= owner_idx;
              beat_cnt_q   <= '0;
              if (arb_found) begin
                // Hand over directly; no idle bubble between owners.
                grant_q <= arb_onehot;
              end else begin
                grant_q <= '0;
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign beat_cnt = beat_cnt_q;

endmodule
